ring_osc_meter: RTL and testbench



---
 rtl/ring_osc_pkg.sv | 16 +
 rtl/osc_edge_sync.sv | 30 +++
 rtl/ring_osc_meter.sv | 153 +++++++++++++++
 tb/tb_ring_osc_meter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_pkg.sv
// Shared definitions for the ring oscillator meter: FSM encoding and default sizing.
package ring_osc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GATE   = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam int DEF_N_OSC         = 4;
   localparam int DEF_CNT_W         = 16;
   localparam int DEF_GATE_W        = 16;
   localparam int DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for one asynchronous oscillator tap, followed by a rising-edge detector.
module osc_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic din,
   output logic rise
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   // The history flop keeps tracking during clear so a tap that is already high
   // when the gate opens is not mistaken for a fresh edge.
   assign rise = sync_reg & ~prev_reg & ~clr;

endmodule

// File: rtl/ring_osc_meter.sv
// Ring oscillator bank sequencer: enables one oscillator at a time, lets it settle,
// counts its divided-tap edges over a programmable gate and reports each count.
module ring_osc_meter
   import ring_osc_pkg::*;
#(
   parameter int N_OSC         = DEF_N_OSC,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int GATE_W        = DEF_GATE_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   localparam int IDX_W        = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_OSC-1:0]  osc_mask,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [N_OSC-1:0]  osc_in,
   output logic [N_OSC-1:0]  osc_en,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [IDX_W-1:0]  res_idx,
   output logic [CNT_W-1:0]  res_count,
   output logic              res_ovf,
   output logic              done
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

   state_t              state_reg, state_next;
   logic [N_OSC-1:0]    mask_reg;
   logic [GATE_W-1:0]   gate_reg;
   logic [IDX_W-1:0]    sel_reg;
   logic [TMR_W-1:0]    timer_reg;
   logic [CNT_W-1:0]    count_reg;
   logic                ovf_reg;
   logic                done_reg;

   logic [N_OSC-1:0]    rise;
   logic [N_OSC-1:0]    sel_onehot;
   logic                rise_sel;
   logic [IDX_W-1:0]    first_idx;
   logic [IDX_W-1:0]    next_idx;
   logic                next_found;
   logic [TMR_W-1:0]    gate_load;

   assign sel_onehot = N_OSC'(1) << sel_reg;
   assign rise_sel   = |(rise & sel_onehot);
   // A zero gate length still opens a one-cycle window.
   assign gate_load  = (gate_reg == '0) ? '0 : TMR_W'(gate_reg - GATE_W'(1));

   for (genvar gi = 0; gi < N_OSC; gi++) begin : g_sync
      osc_edge_sync u_sync (
         .clk  (clk),
         .rst  (rst),
         .clr  ((state_reg == ST_SETTLE) && sel_onehot[gi]),
         .din  (osc_in[gi]),
         .rise (rise[gi])
      );
   end

   always_comb begin
      first_idx  = '0;
      next_idx   = '0;
      next_found = 1'b0;
      for (int i = N_OSC - 1; i >= 0; i--) begin
         if (osc_mask[i]) first_idx = IDX_W'(i);
         if (mask_reg[i] && (i > int'(sel_reg))) begin
            next_found = 1'b1;
            next_idx   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start && (osc_mask != '0)) state_next = ST_SETTLE;
         ST_SETTLE: if (timer_reg == '0) state_next = ST_GATE;
         ST_GATE:   if (timer_reg == '0) state_next = ST_REPORT;
         ST_REPORT: if (res_ready) state_next = next_found ? ST_SETTLE : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_reg  <= '0;
         gate_reg  <= '0;
         sel_reg   <= '0;
         timer_reg <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if (osc_mask != '0) begin
                     mask_reg  <= osc_mask;
                     gate_reg  <= gate_len;
                     sel_reg   <= first_idx;
                     timer_reg <= TMR_W'(SETTLE_CYCLES - 1);
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               count_reg <= '0;
               ovf_reg   <= 1'b0;
               timer_reg <= (timer_reg == '0) ? gate_load : timer_reg - TMR_W'(1);
            end
            ST_GATE: begin
               if (rise_sel) begin
                  if (&count_reg) ovf_reg   <= 1'b1;
                  else            count_reg <= count_reg + CNT_W'(1);
               end
               if (timer_reg != '0) timer_reg <= timer_reg - TMR_W'(1);
            end
            ST_REPORT: begin
               if (res_ready) begin
                  if (next_found) begin
                     sel_reg   <= next_idx;
                     timer_reg <= TMR_W'(SETTLE_CYCLES - 1);
                  end else begin
                     done_reg <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state_reg != ST_IDLE);
      osc_en    = ((state_reg == ST_SETTLE) || (state_reg == ST_GATE)) ? sel_onehot : '0;
      res_valid = (state_reg == ST_REPORT);
      res_idx   = res_valid ? sel_reg   : '0;
      res_count = res_valid ? count_reg : '0;
      res_ovf   = res_valid & ovf_reg;
      done      = done_reg;
   end

endmodule

// File: tb/tb_ring_osc_meter.sv
// Self-checking bench for ring_osc_meter: free-running square-wave taps, scan scenarios
// and randomized scans checked against an edge-count window model.
module tb_ring_osc_meter;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int GW = 16;
   localparam int S  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          res_ready = 1'b0;
   logic [N-1:0]  osc_mask = '0;
   logic [N-1:0]  osc_in = '0;
   logic [GW-1:0] gate_len = '0;
   logic [N-1:0]  osc_en;
   logic          busy, res_valid, res_ovf, done;
   logic [1:0]    res_idx;
   logic [CW-1:0] res_count;

   int n_checks = 0;
   int n_fail   = 0;
   int per[N]   = '{10, 10, 10, 10};
   int ph[N]    = '{0, 0, 0, 0};

   ring_osc_meter #(
      .N_OSC(N), .CNT_W(CW), .GATE_W(GW), .SETTLE_CYCLES(S)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .osc_mask(osc_mask), .gate_len(gate_len),
      .osc_in(osc_in), .osc_en(osc_en), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_idx(res_idx), .res_count(res_count),
      .res_ovf(res_ovf), .done(done)
   );

   always #5 clk = ~clk;

   // Square-wave taps, period per[i] clk cycles, high for the first half of each period.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         ph[i] = (ph[i] + 1) % per[i];
         osc_in[i] = (ph[i] < per[i] / 2);
      end
   end

   // Any L-cycle window of a period-P wave holds floor(L/P) or ceil(L/P) rising edges;
   // allow one more lost edge for the synchronizer delay at the window ends.
   function automatic int exp_lo(input int l, input int p);
      return (l / p >= 1) ? l / p - 1 : 0;
   endfunction

   function automatic int exp_hi(input int l, input int p);
      return (l + p - 1) / p;
   endfunction

   task automatic do_start(input logic [N-1:0] m, input logic [GW-1:0] gl);
      osc_mask = m;
      gate_len = gl;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      osc_mask = N'($urandom);
      gate_len = GW'($urandom);
   endtask

   task automatic wait_valid(input int budget, input logic [N-1:0] en,
                             output int cyc, output bit ok, output int bad);
      cyc = 0;
      bad = 0;
      while (res_valid !== 1'b1 && cyc < budget) begin
         if (osc_en !== en || busy !== 1'b1) bad++;
         @(negedge clk);
         cyc++;
      end
      ok = (res_valid === 1'b1);
      if (ok && osc_en !== '0) bad++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({osc_en, busy, res_valid, res_idx, res_count, res_ovf, done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b busy=%b valid=%b idx=%0d cnt=%0d ovf=%b done=%b, want all 0",
                  osc_en, busy, res_valid, res_idx, res_count, res_ovf, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int cyc, bad;
      bit ok;
      per[1] = 10;
      res_ready = 1'b1;
      do_start(4'b0010, 16'd100);
      n_checks++;
      if (busy !== 1'b1 || osc_en !== 4'b0010) begin
         n_fail++;
         $display("FAIL single_start: busy=%b osc_en=%b, want 1 0010", busy, osc_en);
      end
      wait_valid(S + 150, 4'b0010, cyc, ok, bad);
      n_checks++;
      if (!ok || cyc != S + 100) begin
         n_fail++;
         $display("FAIL single_latency: valid=%b after %0d cycles, want 1 after %0d", ok, cyc, S + 100);
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL single_enable: %0d bad osc_en/busy cycles, want 0", bad);
      end
      $display("single: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (res_idx !== 2'd1 || res_ovf !== 1'b0 || int'(res_count) < 9 || int'(res_count) > 11) begin
         n_fail++;
         $display("FAIL single_result: idx=%0d count=%0d ovf=%b, want idx 1 count 9..11 ovf 0",
                  res_idx, res_count, res_ovf);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%b busy=%b valid=%b, want 1 0 0", done, busy, res_valid);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_pulse: done=%b, want 0", done);
      end
   endtask

   task automatic test_backpressure();
      int cyc, bad, dones;
      bit ok;
      logic [CW-1:0] c1;
      per[1] = 8;
      per[3] = 12;
      res_ready = 1'b0;
      do_start(4'b1010, 16'd60);
      wait_valid(S + 100, 4'b0010, cyc, ok, bad);
      c1 = res_count;
      $display("backpressure first: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || bad != 0 || res_idx !== 2'd1 || int'(c1) < exp_lo(60, 8) || int'(c1) > exp_hi(60, 8)) begin
         n_fail++;
         $display("FAIL bp_first: ok=%b bad=%0d idx=%0d count=%0d, want 1 0 1 %0d..%0d",
                  ok, bad, res_idx, c1, exp_lo(60, 8), exp_hi(60, 8));
      end
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_idx !== 2'd1 || res_count !== c1 || osc_en !== '0 || done !== 1'b0)
            bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles while stalled, want 0", bad);
      end
      res_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || osc_en !== 4'b1000 || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_advance: valid=%b en=%b busy=%b done=%b, want 0 1000 1 0",
                  res_valid, osc_en, busy, done);
      end
      wait_valid(S + 100, 4'b1000, cyc, ok, bad);
      $display("backpressure second: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || bad != 0 || cyc != S + 60 || res_idx !== 2'd3 ||
          int'(res_count) < exp_lo(60, 12) || int'(res_count) > exp_hi(60, 12)) begin
         n_fail++;
         $display("FAIL bp_second: ok=%b bad=%0d cyc=%0d idx=%0d count=%0d, want 1 0 %0d 3 %0d..%0d",
                  ok, bad, cyc, res_idx, res_count, S + 60, exp_lo(60, 12), exp_hi(60, 12));
      end
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_done: %0d done pulses busy=%b, want 1 0", dones, busy);
      end
   endtask

   task automatic test_saturation();
      int cyc, bad;
      bit ok;
      per[0] = 2;
      res_ready = 1'b1;
      do_start(4'b0001, 16'd1000);
      wait_valid(S + 1100, 4'b0001, cyc, ok, bad);
      $display("saturation: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || res_count !== 8'd255 || res_ovf !== 1'b1 || res_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL saturation: ok=%b idx=%0d count=%0d ovf=%b, want 1 0 255 1",
                  ok, res_idx, res_count, res_ovf);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_done: done=%b, want 1", done);
      end
   endtask

   task automatic test_degenerate();
      int cyc, bad;
      bit ok;
      do_start(4'b0000, 16'd50);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || osc_en !== '0) begin
         n_fail++;
         $display("FAIL empty_mask: done=%b busy=%b en=%b, want 1 0 0000", done, busy, osc_en);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_mask_after: done=%b busy=%b, want 0 0", done, busy);
      end
      per[2] = 4;
      res_ready = 1'b1;
      do_start(4'b0100, 16'd0);
      wait_valid(S + 20, 4'b0100, cyc, ok, bad);
      $display("zero gate: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || cyc != S + 1 || res_idx !== 2'd2 || int'(res_count) > 1) begin
         n_fail++;
         $display("FAIL zero_gate: ok=%b cyc=%0d idx=%0d count=%0d, want 1 %0d 2 <=1",
                  ok, cyc, res_idx, res_count, S + 1);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc, bad;
      bit ok;
      per[3] = 6;
      res_ready = 1'b1;
      do_start(4'b1000, 16'd200);
      repeat (S + 50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({osc_en, busy, res_valid, res_idx, res_count, res_ovf, done} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: en=%b busy=%b valid=%b done=%b, want all 0", osc_en, busy, res_valid, done);
      end
      rst = 1'b0;
      bad = 0;
      repeat (250) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0 || osc_en !== '0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: %0d active cycles after reset, want 0", bad);
      end
      do_start(4'b1000, 16'd90);
      wait_valid(S + 120, 4'b1000, cyc, ok, bad);
      $display("after reset: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || bad != 0 || cyc != S + 90 || res_idx !== 2'd3 ||
          int'(res_count) < exp_lo(90, 6) || int'(res_count) > exp_hi(90, 6)) begin
         n_fail++;
         $display("FAIL reset_restart: ok=%b bad=%0d cyc=%0d idx=%0d count=%0d, want 1 0 %0d 3 %0d..%0d",
                  ok, bad, cyc, res_idx, res_count, S + 90, exp_lo(90, 6), exp_hi(90, 6));
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_start_busy();
      int cyc, bad;
      bit ok;
      per[0] = 5;
      per[2] = 7;
      res_ready = 1'b1;
      do_start(4'b0101, 16'd70);
      repeat (S + 10) @(negedge clk);
      osc_mask = 4'b1010;
      gate_len = 16'd5;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || osc_en !== 4'b0001) begin
         n_fail++;
         $display("FAIL busy_start_en: busy=%b en=%b, want 1 0001", busy, osc_en);
      end
      wait_valid(200, 4'b0001, cyc, ok, bad);
      $display("start-busy first: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || bad != 0 || res_idx !== 2'd0 ||
          int'(res_count) < exp_lo(70, 5) || int'(res_count) > exp_hi(70, 5)) begin
         n_fail++;
         $display("FAIL busy_first: ok=%b bad=%0d idx=%0d count=%0d, want 1 0 0 %0d..%0d",
                  ok, bad, res_idx, res_count, exp_lo(70, 5), exp_hi(70, 5));
      end
      @(negedge clk);
      wait_valid(S + 120, 4'b0100, cyc, ok, bad);
      $display("start-busy second: idx=%0d count=%0d ovf=%b", res_idx, res_count, res_ovf);
      n_checks++;
      if (!ok || bad != 0 || cyc != S + 70 || res_idx !== 2'd2 ||
          int'(res_count) < exp_lo(70, 7) || int'(res_count) > exp_hi(70, 7)) begin
         n_fail++;
         $display("FAIL busy_second: ok=%b bad=%0d cyc=%0d idx=%0d count=%0d, want 1 0 %0d 2 %0d..%0d",
                  ok, bad, cyc, res_idx, res_count, S + 70, exp_lo(70, 7), exp_hi(70, 7));
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_done: done=%b busy=%b, want 1 0", done, busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int cyc, bad, gl, hold;
      bit ok;
      logic [N-1:0] m;
      logic [CW-1:0] c;
      int exp_idx[$];
      res_ready = 1'b0;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < N; i++) per[i] = 4 + int'($urandom_range(0, 9));
         m  = N'($urandom_range(1, 15));
         gl = int'($urandom_range(1, 150));
         exp_idx.delete();
         for (int i = 0; i < N; i++) if (m[i]) exp_idx.push_back(i);
         do_start(m, GW'(gl));
         while (exp_idx.size() > 0) begin
            int e;
            e = exp_idx.pop_front();
            wait_valid(S + gl + 20, N'(1) << e, cyc, ok, bad);
            $display("random it=%0d mask=%b idx=%0d count=%0d ovf=%b (gate %0d period %0d)",
                     it, m, res_idx, res_count, res_ovf, gl, per[e]);
            n_checks++;
            if (!ok || bad != 0 || cyc != S + gl || int'(res_idx) != e || res_ovf !== 1'b0 ||
                int'(res_count) < exp_lo(gl, per[e]) || int'(res_count) > exp_hi(gl, per[e])) begin
               n_fail++;
               $display("FAIL random_result: ok=%b bad=%0d cyc=%0d idx=%0d count=%0d ovf=%b, want 1 0 %0d %0d %0d..%0d 0",
                        ok, bad, cyc, res_idx, res_count, res_ovf, S + gl, e,
                        exp_lo(gl, per[e]), exp_hi(gl, per[e]));
            end
            c = res_count;
            hold = int'($urandom_range(0, 4));
            bad = 0;
            repeat (hold) begin
               @(negedge clk);
               if (res_valid !== 1'b1 || int'(res_idx) != e || res_count !== c) bad++;
            end
            n_checks++;
            if (bad != 0) begin
               n_fail++;
               $display("FAIL random_hold: %0d unstable cycles, want 0", bad);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
         end
         n_checks++;
         if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_done: done=%b busy=%b, want 1 0", done, busy);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_saturation();
      test_degenerate();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
